// File: rtl/id_ex_issue_if.sv
// Decode/EX-stage handshake bundle for the id_ex_issue pipeline register.
// master = decode + downstream pipeline side, slave = the issue register.
interface id_ex_issue_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 6,
  parameter int CNT_W  = 16
);
  logic              dec_valid;
  logic              dec_ready;
  logic [OP_W-1:0]   dec_operation;
  logic [4:0]        dec_rs;
  logic [4:0]        dec_rt;
  logic [4:0]        dec_rd;
  logic [DATA_W-1:0] dec_rs_data;
  logic [DATA_W-1:0] dec_rt_data;
  logic [DATA_W-1:0] dec_imm;
  logic              dec_use_imm;
  logic [4:0]        dec_shamt;
  logic              dec_use_shamt;
  logic              dec_reg_write;
  logic              dec_is_load;

  logic [DATA_W-1:0] alu_result;
  logic              exmem_reg_write;
  logic [4:0]        exmem_rd;
  logic              exmem_is_load;
  logic [DATA_W-1:0] exmem_result;
  logic              memwb_reg_write;
  logic [4:0]        memwb_rd;
  logic [DATA_W-1:0] memwb_result;
  logic              ex_hold;
  logic              flush;

  logic              ex_valid;
  logic [DATA_W-1:0] ex_op1;
  logic [DATA_W-1:0] ex_op2;
  logic [OP_W-1:0]   ex_operation;
  logic [5:0]        ex_shift_amount;
  logic [4:0]        ex_rd;
  logic              ex_reg_write;
  logic              ex_is_load;
  logic [CNT_W-1:0]  bubble_count;

  modport master (
    output dec_valid, dec_operation, dec_rs, dec_rt, dec_rd,
           dec_rs_data, dec_rt_data, dec_imm, dec_use_imm,
           dec_shamt, dec_use_shamt, dec_reg_write, dec_is_load,
           alu_result, exmem_reg_write, exmem_rd, exmem_is_load, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result, ex_hold, flush,
    input  dec_ready, ex_valid, ex_op1, ex_op2, ex_operation, ex_shift_amount,
           ex_rd, ex_reg_write, ex_is_load, bubble_count
  );

  modport slave (
    input  dec_valid, dec_operation, dec_rs, dec_rt, dec_rd,
           dec_rs_data, dec_rt_data, dec_imm, dec_use_imm,
           dec_shamt, dec_use_shamt, dec_reg_write, dec_is_load,
           alu_result, exmem_reg_write, exmem_rd, exmem_is_load, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result, ex_hold, flush,
    output dec_ready, ex_valid, ex_op1, ex_op2, ex_operation, ex_shift_amount,
           ex_rd, ex_reg_write, ex_is_load, bubble_count
  );
endinterface

// File: rtl/id_ex_issue.sv
// Decode-to-execute pipeline register: operand bypass resolved at capture,
// load-use bubble insertion, downstream hold and branch flush.
module id_ex_issue #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 6,
  parameter int CNT_W  = 16
) (
  input logic         clk,
  input logic         rst,
  id_ex_issue_if.slave bus
);
  localparam logic [OP_W-1:0] OP_LUI = OP_W'(12);

  logic              vld_p1;
  logic [DATA_W-1:0] op1_p1;
  logic [DATA_W-1:0] op2_p1;
  logic [OP_W-1:0]   opn_p1;
  logic [5:0]        sh_p1;
  logic [4:0]        rd_p1;
  logic              rw_p1;
  logic              ld_p1;
  logic [CNT_W-1:0]  cnt_p1;

  logic              rs_used;
  logic              rt_used;
  logic              ex_wr;
  logic              ex_ld;
  logic              exmem_ld;
  logic              ld_rs;
  logic              ld_rt;
  logic              hz;
  logic [DATA_W-1:0] rs_fwd;
  logic [DATA_W-1:0] rt_fwd;

  function automatic logic hit(input logic we, input logic [4:0] rd,
                               input logic [4:0] src);
    return we && (rd != 5'd0) && (rd == src);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Bypass picks the youngest producer: EX (live ALU), then EX/MEM, then MEM/WB.
  function automatic logic [DATA_W-1:0] bypass(
    input logic [4:0]        src,
    input logic [DATA_W-1:0] rf_val,
    input logic              ex_we,
    input logic [4:0]        ex_dst,
    input logic [DATA_W-1:0] ex_val,
    input logic              em_we,
    input logic [4:0]        em_dst,
    input logic [DATA_W-1:0] em_val,
    input logic              mw_we,
    input logic [4:0]        mw_dst,
    input logic [DATA_W-1:0] mw_val
  );
    if (hit(ex_we, ex_dst, src))      return ex_val;
    else if (hit(em_we, em_dst, src)) return em_val;
    else if (hit(mw_we, mw_dst, src)) return mw_val;
    else                              return rf_val;
  endfunction

  assign rs_used  = (bus.dec_operation != OP_LUI);
  assign rt_used  = ~bus.dec_use_imm;
  assign ex_wr    = vld_p1 & rw_p1;
  assign ex_ld    = vld_p1 & ld_p1;
  assign exmem_ld = bus.exmem_reg_write & bus.exmem_is_load;

  // A load's data is not available until MEM/WB, so EX and EX/MEM loads stall.
  assign ld_rs = hit(ex_ld, rd_p1, bus.dec_rs) | hit(exmem_ld, bus.exmem_rd, bus.dec_rs);
  assign ld_rt = hit(ex_ld, rd_p1, bus.dec_rt) | hit(exmem_ld, bus.exmem_rd, bus.dec_rt);
  assign hz    = bus.dec_valid & ((rs_used & ld_rs) | (rt_used & ld_rt));

  assign rs_fwd = bypass(bus.dec_rs, bus.dec_rs_data,
                         ex_wr, rd_p1, bus.alu_result,
                         bus.exmem_reg_write, bus.exmem_rd, bus.exmem_result,
                         bus.memwb_reg_write, bus.memwb_rd, bus.memwb_result);
  assign rt_fwd = bypass(bus.dec_rt, bus.dec_rt_data,
                         ex_wr, rd_p1, bus.alu_result,
                         bus.exmem_reg_write, bus.exmem_rd, bus.exmem_result,
                         bus.memwb_reg_write, bus.memwb_rd, bus.memwb_result);

  assign bus.dec_ready = ~rst & (bus.flush | (~bus.ex_hold & ~hz));

  // ---- decode -> EX register boundary ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      op1_p1 <= '0;
      op2_p1 <= '0;
      opn_p1 <= '0;
      sh_p1  <= '0;
      rd_p1  <= '0;
      rw_p1  <= 1'b0;
      ld_p1  <= 1'b0;
      cnt_p1 <= '0;
    end else if (bus.flush) begin
      vld_p1 <= 1'b0;
      rw_p1  <= 1'b0;
      ld_p1  <= 1'b0;
    end else if (!bus.ex_hold) begin
      if (hz) begin
        vld_p1 <= 1'b0;
        rw_p1  <= 1'b0;
        ld_p1  <= 1'b0;
        cnt_p1 <= sat_inc(cnt_p1);
      end else if (bus.dec_valid) begin
        vld_p1 <= 1'b1;
        op1_p1 <= rs_fwd;
        op2_p1 <= bus.dec_use_imm ? bus.dec_imm : rt_fwd;
        opn_p1 <= bus.dec_operation;
        sh_p1  <= bus.dec_use_shamt ? {1'b0, bus.dec_shamt} : {1'b0, rs_fwd[4:0]};
        rd_p1  <= bus.dec_rd;
        rw_p1  <= bus.dec_reg_write;
        ld_p1  <= bus.dec_is_load;
      end else begin
        vld_p1 <= 1'b0;
        rw_p1  <= 1'b0;
        ld_p1  <= 1'b0;
      end
    end
  end

  assign bus.ex_valid        = vld_p1;
  assign bus.ex_op1          = op1_p1;
  assign bus.ex_op2          = op2_p1;
  assign bus.ex_operation    = opn_p1;
  assign bus.ex_shift_amount = sh_p1;
  assign bus.ex_rd           = rd_p1;
  assign bus.ex_reg_write    = rw_p1;
  assign bus.ex_is_load      = ld_p1;
  assign bus.bubble_count    = cnt_p1;
endmodule

// File: tb/tb_id_ex_issue.sv
// Directed bench for id_ex_issue: reference model of the issue register plus
// hand-computed spot checks of bypass, load-use, hold/flush and shift cases.
module tb_id_ex_issue;
  localparam int DW   = 32;
  localparam int OW   = 6;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_issue_if #(.DATA_W(DW), .OP_W(OW), .CNT_W(CW)) bus ();
  id_ex_issue #(.DATA_W(DW), .OP_W(OW), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  // Model of the architectural contents of the EX register
  logic          m_vld, m_rw, m_ld;
  logic [DW-1:0] m_op1, m_op2;
  logic [OW-1:0] m_opn;
  logic [5:0]    m_sh;
  logic [4:0]    m_rd;
  int            m_cnt;

  function automatic logic [DW-1:0] ref_alu(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [OW-1:0] op, input logic [5:0] sh);
    case (op)
      6'd0:    return a + b;
      6'd1:    return a - b;
      6'd11:   return $unsigned($signed(b) >>> sh);
      6'd12:   return b;
      default: return a + b;
    endcase
  endfunction

  assign bus.alu_result = ref_alu(m_op1, m_op2, m_opn, m_sh);

  // Value a source register reads at decode: newest in-flight writer wins.
  function automatic logic [DW-1:0] m_operand(input logic [4:0] r, input logic [DW-1:0] rf);
    logic          we  [3];
    logic [4:0]    dst [3];
    logic [DW-1:0] val [3];
    we[0] = m_vld && m_rw;        dst[0] = m_rd;         val[0] = bus.alu_result;
    we[1] = bus.exmem_reg_write;  dst[1] = bus.exmem_rd; val[1] = bus.exmem_result;
    we[2] = bus.memwb_reg_write;  dst[2] = bus.memwb_rd; val[2] = bus.memwb_result;
    if (r == 5'd0) return rf;
    for (int i = 0; i < 3; i++)
      if (we[i] && dst[i] == r) return val[i];
    return rf;
  endfunction

  function automatic logic m_stall();
    logic [4:0] src  [2];
    logic       used [2];
    logic [4:0] ldr  [2];
    logic       ldon [2];
    src[0] = bus.dec_rs;  used[0] = (bus.dec_operation != 6'd12);
    src[1] = bus.dec_rt;  used[1] = !bus.dec_use_imm;
    ldon[0] = m_vld && m_ld;                           ldr[0] = m_rd;
    ldon[1] = bus.exmem_reg_write && bus.exmem_is_load; ldr[1] = bus.exmem_rd;
    if (!bus.dec_valid) return 1'b0;
    for (int s = 0; s < 2; s++)
      for (int l = 0; l < 2; l++)
        if (used[s] && ldon[l] && src[s] != 5'd0 && src[s] == ldr[l]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic m_ready();
    return !rst && (bus.flush || (!bus.ex_hold && !m_stall()));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_vld <= 0; m_rw <= 0; m_ld <= 0; m_op1 <= 0; m_op2 <= 0;
      m_opn <= 0; m_sh <= 0; m_rd <= 0; m_cnt <= 0;
    end else if (bus.flush) begin
      m_vld <= 0; m_rw <= 0; m_ld <= 0;
    end else if (!bus.ex_hold) begin
      if (m_stall()) begin
        m_vld <= 0; m_rw <= 0; m_ld <= 0;
        m_cnt <= (m_cnt == CMAX) ? CMAX : m_cnt + 1;
      end else if (bus.dec_valid) begin
        m_vld <= 1;
        m_op1 <= m_operand(bus.dec_rs, bus.dec_rs_data);
        m_op2 <= bus.dec_use_imm ? bus.dec_imm : m_operand(bus.dec_rt, bus.dec_rt_data);
        m_opn <= bus.dec_operation;
        m_sh  <= bus.dec_use_shamt ? {1'b0, bus.dec_shamt}
                                   : {1'b0, m_operand(bus.dec_rs, bus.dec_rs_data) % 32};
        m_rd  <= bus.dec_rd;
        m_rw  <= bus.dec_reg_write;
        m_ld  <= bus.dec_is_load;
      end else begin
        m_vld <= 0; m_rw <= 0; m_ld <= 0;
      end
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_ready",  32'(bus.dec_ready),    32'(m_ready()));
      chk("m_valid",  32'(bus.ex_valid),     32'(m_vld));
      chk("m_rw",     32'(bus.ex_reg_write), 32'(m_rw));
      chk("m_ld",     32'(bus.ex_is_load),   32'(m_ld));
      chk("m_bubble", 32'(bus.bubble_count), 32'(m_cnt));
      if (m_vld) begin
        chk("m_op1", bus.ex_op1, m_op1);
        chk("m_op2", bus.ex_op2, m_op2);
        chk("m_opn", 32'(bus.ex_operation),    32'(m_opn));
        chk("m_sh",  32'(bus.ex_shift_amount), 32'(m_sh));
        chk("m_rd",  32'(bus.ex_rd),           32'(m_rd));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_fwd();
    bus.exmem_reg_write = 0; bus.exmem_rd = 0; bus.exmem_is_load = 0; bus.exmem_result = 0;
    bus.memwb_reg_write = 0; bus.memwb_rd = 0; bus.memwb_result = 0;
  endtask

  task automatic idle();
    bus.dec_valid = 0; bus.dec_operation = 0; bus.dec_rs = 0; bus.dec_rt = 0; bus.dec_rd = 0;
    bus.dec_rs_data = 0; bus.dec_rt_data = 0; bus.dec_imm = 0; bus.dec_use_imm = 0;
    bus.dec_shamt = 0; bus.dec_use_shamt = 0; bus.dec_reg_write = 0; bus.dec_is_load = 0;
  endtask

  task automatic issue(input logic [OW-1:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [DW-1:0] rsd, input logic [DW-1:0] rtd,
                       input logic [DW-1:0] imm, input logic use_imm, input logic [4:0] shamt,
                       input logic use_shamt, input logic rw, input logic ld);
    bus.dec_valid = 1; bus.dec_operation = op; bus.dec_rs = rs; bus.dec_rt = rt; bus.dec_rd = rd;
    bus.dec_rs_data = rsd; bus.dec_rt_data = rtd; bus.dec_imm = imm; bus.dec_use_imm = use_imm;
    bus.dec_shamt = shamt; bus.dec_use_shamt = use_shamt; bus.dec_reg_write = rw;
    bus.dec_is_load = ld;
  endtask

  task automatic set_exmem(input logic we, input logic [4:0] rd, input logic ld, input logic [DW-1:0] v);
    bus.exmem_reg_write = we; bus.exmem_rd = rd; bus.exmem_is_load = ld; bus.exmem_result = v;
  endtask

  initial begin
    rst = 1; bus.ex_hold = 0; bus.flush = 0;
    clear_fwd();
    issue(6'd0, 5'd1, 5'd2, 5'd3, 32'd2, 32'd1, 32'd0, 0, 5'd0, 0, 1, 0);
    tick();
    chk_en = 1;
    tick();
    #1;
    chk("rst_ready",  32'(bus.dec_ready), 32'd0);
    chk("rst_valid",  32'(bus.ex_valid), 32'd0);
    chk("rst_op1",    bus.ex_op1, 32'd0);
    chk("rst_op2",    bus.ex_op2, 32'd0);
    chk("rst_rd",     32'(bus.ex_rd), 32'd0);
    chk("rst_rw",     32'(bus.ex_reg_write), 32'd0);
    chk("rst_bubble", 32'(bus.bubble_count), 32'd0);
    rst = 0;

    // add r3 = r1 + r2, then sub r4 = r3 - r2 with stale rf r3
    tick();
    chk("add_op1", bus.ex_op1, 32'd2);
    issue(6'd1, 5'd3, 5'd2, 5'd4, 32'd0, 32'd1, 32'd0, 0, 5'd0, 0, 1, 0);
    tick();
    chk("ex_bypass_op1", bus.ex_op1, 32'd3);
    chk("ex_bypass_opn", 32'(bus.ex_operation), 32'd1);

    // EX/MEM beats MEM/WB on r5
    issue(6'd0, 5'd5, 5'd0, 5'd0, 32'd100, 32'd55, 32'd0, 0, 5'd0, 0, 1, 0);
    set_exmem(1, 5'd5, 0, 32'd7);
    bus.memwb_reg_write = 1; bus.memwb_rd = 5'd5; bus.memwb_result = 32'd9;
    tick();
    chk("prio_op1", bus.ex_op1, 32'd7);
    chk("prio_op2", bus.ex_op2, 32'd55);

    // every stage writes r0: register-file value must be used
    issue(6'd0, 5'd0, 5'd0, 5'd8, 32'd123, 32'd4, 32'd0, 0, 5'd0, 0, 1, 0);
    set_exmem(1, 5'd0, 0, 32'd7);
    bus.memwb_rd = 5'd0;
    tick();
    chk("r0_op1", bus.ex_op1, 32'd123);

    // lw r6 then add r7 = r6 + r1
    clear_fwd();
    issue(6'd0, 5'd1, 5'd0, 5'd6, 32'd10, 32'd0, 32'd4, 1, 5'd0, 0, 1, 1);
    tick();
    issue(6'd0, 5'd6, 5'd1, 5'd7, 32'd0, 32'd1, 32'd0, 0, 5'd0, 0, 1, 0);
    #1;
    chk("lu_ready1", 32'(bus.dec_ready), 32'd0);
    tick();
    chk("lu_bub1", 32'(bus.bubble_count), 32'd1);
    set_exmem(1, 5'd6, 1, 32'd14);
    #1;
    chk("lu_ready2", 32'(bus.dec_ready), 32'd0);
    tick();
    chk("lu_bub2",   32'(bus.bubble_count), 32'd2);
    chk("lu_valid2", 32'(bus.ex_valid), 32'd0);
    set_exmem(0, 5'd0, 0, 32'd0);
    bus.memwb_reg_write = 1; bus.memwb_rd = 5'd6; bus.memwb_result = 32'd77;
    #1;
    chk("lu_ready3", 32'(bus.dec_ready), 32'd1);
    tick();
    chk("lu_op1", bus.ex_op1, 32'd77);
    chk("lu_rd",  32'(bus.ex_rd), 32'd7);

    // hold for 3 cycles with a load-use hazard present, then flush under hold
    clear_fwd();
    bus.ex_hold = 1;
    set_exmem(1, 5'd1, 1, 32'd0);
    issue(6'd0, 5'd1, 5'd2, 5'd8, 32'd5, 32'd6, 32'd0, 0, 5'd0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_ready", 32'(bus.dec_ready), 32'd0);
      tick();
      chk("hold_op1",    bus.ex_op1, 32'd77);
      chk("hold_valid",  32'(bus.ex_valid), 32'd1);
      chk("hold_bubble", 32'(bus.bubble_count), 32'd2);
    end
    bus.flush = 1;
    #1;
    chk("flush_ready", 32'(bus.dec_ready), 32'd1);
    tick();
    chk("flush_valid",  32'(bus.ex_valid), 32'd0);
    chk("flush_bubble", 32'(bus.bubble_count), 32'd2);
    bus.flush = 0; bus.ex_hold = 0;

    // lui ignores rs even when it names a pending load
    set_exmem(1, 5'd9, 1, 32'd0);
    issue(6'd12, 5'd9, 5'd0, 5'd10, 32'hdead, 32'd0, 32'h0001_0000, 1, 5'd0, 0, 1, 0);
    #1;
    chk("lui_ready", 32'(bus.dec_ready), 32'd1);
    tick();
    chk("lui_op2",   bus.ex_op2, 32'h0001_0000);
    chk("lui_valid", 32'(bus.ex_valid), 32'd1);
    clear_fwd();

    // sra with constant shift, then variable shift from rs
    issue(6'd11, 5'd0, 5'd11, 5'd12, 32'd0, 32'hFFFF_FFC0, 32'd0, 0, 5'd4, 1, 1, 0);
    tick();
    chk("sra_shamt", 32'(bus.ex_shift_amount), 32'd4);
    chk("sra_op2",   bus.ex_op2, 32'hFFFF_FFC0);
    issue(6'd10, 5'd13, 5'd14, 5'd13, 32'h25, 32'd2, 32'd0, 0, 5'd9, 0, 1, 0);
    tick();
    chk("var_shamt", 32'(bus.ex_shift_amount), 32'd5);

    // no decode: plain bubble, counter unchanged
    idle();
    tick();
    chk("idle_valid",  32'(bus.ex_valid), 32'd0);
    chk("idle_rw",     32'(bus.ex_reg_write), 32'd0);
    chk("idle_bubble", 32'(bus.bubble_count), 32'd2);

    // long stall saturates the counter
    set_exmem(1, 5'd6, 1, 32'd0);
    issue(6'd0, 5'd6, 5'd0, 5'd15, 32'd0, 32'd0, 32'd1, 1, 5'd0, 0, 1, 0);
    for (int i = 0; i < 8; i++) tick();
    chk("sat_bubble", 32'(bus.bubble_count), 32'(CMAX));

    // reset in the middle of a stall
    rst = 1;
    #1;
    chk("rst_stall_ready", 32'(bus.dec_ready), 32'd0);
    tick();
    chk("rst_stall_valid",  32'(bus.ex_valid), 32'd0);
    chk("rst_stall_bubble", 32'(bus.bubble_count), 32'd0);
    rst = 0;
    idle();
    clear_fwd();
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
